// File: rtl/io_hub_pkg.sv
// Shared definitions for the io_hub peripheral: register map, bit positions
// inside CTRL/STATUS/INT_PEND, and the transmit sequencer state encoding.
package io_hub_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'd0;
  localparam logic [7:0] OFF_STATUS   = 8'd1;
  localparam logic [7:0] OFF_TXDATA   = 8'd2;
  localparam logic [7:0] OFF_RXDATA   = 8'd3;
  localparam logic [7:0] OFF_GPIO_OUT = 8'd4;
  localparam logic [7:0] OFF_GPIO_DIR = 8'd5;
  localparam logic [7:0] OFF_GPIO_IN  = 8'd6;
  localparam logic [7:0] OFF_INT_VEC  = 8'd7;
  localparam logic [7:0] OFF_INT_PEND = 8'd8;
  localparam logic [7:0] OFF_LAST     = OFF_INT_PEND;

  localparam int CTRL_TX_EN       = 0;
  localparam int CTRL_RX_EN       = 1;
  localparam int CTRL_GPIO_INT_EN = 2;
  localparam int CTRL_RX_INT_EN   = 3;
  localparam int CTRL_W           = 4;

  localparam int ST_TXQ_FULL   = 0;
  localparam int ST_TXQ_EMPTY  = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_DROP    = 4;
  localparam int ST_TX_ACTIVE  = 5;

  localparam int PEND_RX   = 0;
  localparam int PEND_GPIO = 1;
  localparam int PEND_W    = 2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

  function automatic logic [7:0] status_word(
    input logic txq_full,
    input logic txq_empty,
    input logic rx_avail,
    input logic rx_overrun,
    input logic tx_drop,
    input logic tx_active
  );
    logic [7:0] s;
    s = '0;
    s[ST_TXQ_FULL]   = txq_full;
    s[ST_TXQ_EMPTY]  = txq_empty;
    s[ST_RX_AVAIL]   = rx_avail;
    s[ST_RX_OVERRUN] = rx_overrun;
    s[ST_TX_DROP]    = tx_drop;
    s[ST_TX_ACTIVE]  = tx_active;
    return s;
  endfunction

endpackage

// File: rtl/io_hub_fifo.sv
// Byte-wide transmit queue. A push is judged against fullness at the start of
// the cycle, so a push into a full queue is lost even if a pop happens too.
module io_hub_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] w_data,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= w_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_hub.sv
// Memory-mapped IO hub: UART transmit queue and sequencer, single-byte receive
// holding register, GPIO with synchronised inputs, and a two-source interrupt.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int         GPIO_W    = 8,
  parameter int         TXQ_DEPTH = 4,
  parameter logic [7:0] BASE      = 8'hF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        addr,
  input  logic [7:0]        w_data,
  input  logic              w_en,
  input  logic              r_en,
  output logic [7:0]        r_data,
  output logic              hit,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              int_req,
  output logic [7:0]        int_vec,
  output tx_state_e         tx_state
);

  // Handshakes: w_en/r_en are single-cycle strobes qualifying addr (and
  // w_data) in that cycle; rx_valid and tx_start are one-cycle pulses with
  // their byte valid in the same cycle; tx_busy is a level from the UART.

  logic [8:0]        addr_ext;
  logic [7:0]        off;
  logic              wr;
  logic              rd;

  logic [CTRL_W-1:0] ctrl;
  logic [GPIO_W-1:0] gpio_out_r;
  logic [GPIO_W-1:0] gpio_dir_r;
  logic [7:0]        int_vec_r;
  logic [PEND_W-1:0] int_pend;
  logic [7:0]        rx_data;
  logic              rx_avail;
  logic              rx_overrun;
  logic              tx_drop;
  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic [GPIO_W-1:0] gpio_prev;

  logic              txq_push;
  logic              txq_pop;
  logic              txq_full;
  logic              txq_empty;
  logic [7:0]        txq_head;

  logic              tx_active;
  logic              rx_accept;
  logic              rx_load;
  logic              gpio_rise;
  logic [PEND_W-1:0] pend_set;
  logic [PEND_W-1:0] pend_clr;

  assign addr_ext = {1'b0, addr};
  assign hit      = (addr_ext >= {1'b0, BASE}) &&
                    (addr_ext <= ({1'b0, BASE} + {1'b0, OFF_LAST}));
  assign off      = addr - BASE;
  assign wr       = w_en && hit;
  assign rd       = r_en && hit;

  assign txq_push  = wr && (off == OFF_TXDATA);
  assign txq_pop   = (tx_state == TX_START);
  assign tx_active = (tx_state != TX_IDLE);

  assign rx_accept = rx_valid && ctrl[CTRL_RX_EN];
  assign rx_load   = rd && (off == OFF_RXDATA);
  assign gpio_rise = |(gpio_s2 & ~gpio_prev);

  always_comb begin
    pend_set            = '0;
    pend_set[PEND_RX]   = rx_accept && ctrl[CTRL_RX_INT_EN];
    pend_set[PEND_GPIO] = gpio_rise && ctrl[CTRL_GPIO_INT_EN];
    pend_clr            = '0;
    if (wr && (off == OFF_INT_PEND)) begin
      pend_clr = w_data[PEND_W-1:0];
    end
  end

  io_hub_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clock  (clock),
    .reset  (reset),
    .push   (txq_push),
    .pop    (txq_pop),
    .w_data (w_data),
    .full   (txq_full),
    .empty  (txq_empty),
    .head   (txq_head)
  );

  always_comb begin
    r_data = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:     r_data = 8'(ctrl);
        OFF_STATUS:   r_data = status_word(txq_full, txq_empty, rx_avail,
                                           rx_overrun, tx_drop, tx_active);
        OFF_RXDATA:   r_data = rx_data;
        OFF_GPIO_OUT: r_data = 8'(gpio_out_r);
        OFF_GPIO_DIR: r_data = 8'(gpio_dir_r);
        OFF_GPIO_IN:  r_data = 8'(gpio_s2);
        OFF_INT_VEC:  r_data = int_vec_r;
        OFF_INT_PEND: r_data = 8'(int_pend);
        default:      r_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl       <= '0;
      gpio_out_r <= '0;
      gpio_dir_r <= '0;
      int_vec_r  <= '0;
      int_pend   <= '0;
      int_req    <= 1'b0;
      tx_drop    <= 1'b0;
      gpio_s1    <= '0;
      gpio_s2    <= '0;
      gpio_prev  <= '0;
    end else begin
      if (wr) begin
        case (off)
          OFF_CTRL:     ctrl       <= w_data[CTRL_W-1:0];
          OFF_GPIO_OUT: gpio_out_r <= w_data[GPIO_W-1:0];
          OFF_GPIO_DIR: gpio_dir_r <= w_data[GPIO_W-1:0];
          OFF_INT_VEC:  int_vec_r  <= w_data;
          default:      ;
        endcase
      end
      if (txq_push && txq_full) begin
        tx_drop <= 1'b1;
      end else if (wr && (off == OFF_STATUS) && w_data[ST_TX_DROP]) begin
        tx_drop <= 1'b0;
      end
      gpio_s1   <= gpio_in;
      gpio_s2   <= gpio_s1;
      gpio_prev <= gpio_s2;
      // A set event in the same cycle as a write-1-to-clear keeps the bit set.
      int_pend  <= (int_pend & ~pend_clr) | pend_set;
      int_req   <= |int_pend;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data    <= '0;
      rx_avail   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_accept) begin
      rx_data    <= rx_byte;
      rx_avail   <= 1'b1;
      rx_overrun <= rx_load ? 1'b0 : (rx_overrun | rx_avail);
    end else if (rx_load) begin
      rx_avail   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

  // tx_start/tx_byte are registered on the IDLE->START transition so the
  // pulse coincides with START, the cycle in which the head is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (ctrl[CTRL_TX_EN] && !txq_empty) begin
            tx_state <= TX_START;
            tx_start <= 1'b1;
            tx_byte  <= txq_head;
          end
        end
        TX_START:     tx_state <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (tx_busy) tx_state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!tx_busy) tx_state <= TX_IDLE;
        default:      tx_state <= TX_IDLE;
      endcase
    end
  end

  assign gpio_out = gpio_out_r;
  assign gpio_oe  = gpio_dir_r;
  assign int_vec  = int_vec_r;

endmodule
